dcache_loader: RTL
==================

# dcache_loader

Preload engine for the data cache's external write port. Accepts a stream of 32-bit words over a valid/ready handshake and writes them to consecutive word addresses through the cache's `data_en` / `input_data` / `input_addr` port. While it runs, it holds the core stalled. It sits beside `writeback_stage`, drives that stage's loader inputs, and is the writer for the port the cache services.

## Interface

Parameters:
- `DPW`, 32: data/address width; matches `rv32i_pkg::DPW`.
- `Depth`, 120: cache size in bytes; must match the cache `Depth`.
- `CntW`, 8: width of the word count.

Ports:
- `clk`, in, 1: clock. All state changes on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: load request. Sampled only in IDLE.
- `base_addr`, in, DPW: byte address of the first word. Sampled with `start`.
- `word_cnt`, in, CntW: number of words to load. Sampled with `start`.
- `s_valid`, in, 1: stream word valid.
- `s_ready`, out, 1: loader can accept a word.
- `s_data`, in, DPW: stream word.
- `data_en`, out, 1: cache write strobe, one cycle per word.
- `input_data`, out, DPW: word to write.
- `input_addr`, out, DPW: byte address of the word.
- `output_check`, in, DPW: cache readback of `input_addr`. Used only with the readback feature.
- `busy`, out, 1: loader active; the core must stall.
- `done`, out, 1: one-cycle pulse when a load ends, normally or on error.
- `err`, out, 3: sticky until the next accepted `start`. Bit 0 = range, bit 1 = alignment, bit 2 = readback mismatch.
- `words_loaded`, out, CntW: number of words written in the current or last load.

## Operation

- States: IDLE, LOAD, VERIFY (present only with the macro), DONE.
- **IDLE**
  - `busy`=0, `s_ready`=0.
  - On `start`: latch `base_addr` and `word_cnt`, clear `err`, clear `words_loaded`.
  - If `base_addr[1:0]`≠0: set err[1] and go to DONE.
  - Else if `base_addr + 4*word_cnt > Depth`: set err[0] and go to DONE. Compute this in DPW+CntW+2 bits so no overflow can occur.
  - Else if `word_cnt`==0: go to DONE.
  - Else: go to LOAD.
  - In every error case, no writes are issued.
- **LOAD**
  - `s_ready`=1.
  - On `s_valid && s_ready`, register `input_data`=`s_data` and `input_addr`=current address, and assert `data_en` in the next cycle.
  - The address increments by 4 and `words_loaded` increments by 1.
  - After the last word, go to DONE. With the macro, go to VERIFY instead.
- **VERIFY**
  - `s_ready`=0, `data_en`=0, `input_addr`/`input_data` held.
  - Compare `output_check` against the held `input_data`. On mismatch, set err[2]; the load continues.
  - Then return to LOAD, or go to DONE if that was the last word.
- **DONE**
  - `done`=1 for one cycle, `busy`=0 next cycle, return to IDLE.
- `start` asserted while not in IDLE is ignored.
- `busy`=1 in LOAD, VERIFY and DONE.

## Timing

- Reset values: state=IDLE; `s_ready`, `data_en`, `busy`, `done`=0; `input_data`, `input_addr`, `err`, `words_loaded`=0.
- Reset asserted mid-load aborts immediately. Partially written cache contents are left as is, and no `done` is issued.
- Word accepted in cycle N → `data_en`=1 in cycle N+1; the cache writes at the end of N+1.
- Without the macro:
  - Throughput is 1 word/cycle.
  - `data_en` for the last word and `done` occur in the same cycle. DONE is entered on the cycle after the last accept.
- With the macro:
  - The compare happens in cycle N+2, and `s_ready` is low during N+1 and N+2.
  - Throughput is 1 word per 3 cycles.
- Error path: `start` in cycle N → `done` in cycle N+1.
- `err` is valid no later than `done` and holds until the next accepted `start`.

## Configuration

- `DCACHE_LOADER_READBACK_EN` defined:
  - VERIFY state exists, `output_check` is compared, and err[2] is live.
- Not defined:
  - No VERIFY state, `output_check` is unused, and err[2] is tied to 0.
  - LOAD asserts `s_ready` continuously.

## Test plan

- Reset, then `start` with base=0, cnt=4, and words 0x11111111..0x44444444 streamed back-to-back → `data_en` pulses at addresses 0, 4, 8, 12 with matching data; `words_loaded`=4; `done` one cycle; err=0.
- base=0x2 → err=3'b010, `done` in the next cycle, no `data_en`.
- base=116, cnt=2 (needs 124 bytes > 120) → err=3'b001, no writes. Then base=116, cnt=1 → one write at 116, err=0.
- cnt=3 with `s_valid` toggling 1,0,0,1,0,1 → exactly 3 writes in order; `s_ready` stays high between gaps; `start` pulsed mid-load is ignored.
- Drop `rst_n` after 2 of 5 words → all outputs 0 immediately, state IDLE, no `done`. A new `start` then works normally.
- Macro defined, with `output_check` forced to 0xDEADBEEF on word 2 → err=3'b100 at `done`, all words still written, `s_ready` low 2 cycles after each accept.

Source files
------------

// File: rtl/dcache_loader.sv
// Purpose: preload engine that streams 32-bit words into the data cache's external write port.
// Latency: a word accepted in cycle N is written (data_en) in N+1; with readback it is compared in N+2.
// Backpressure: s_ready is high only in LOAD (held low during write/compare with readback); busy stalls the core.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, base_addr, word_cnt load request, sampled only in IDLE
//   s_valid, s_ready, s_data   input word stream (valid/ready)
//   data_en, input_data,
//   input_addr                 cache write port, one strobe per word
//   output_check               cache readback of input_addr (readback build only)
//   busy, done, err,
//   words_loaded               status; err = {readback, alignment, range}, sticky until next start
//
// Build option: define DCACHE_LOADER_READBACK_EN to add the VERIFY state and the readback compare.

module dcache_loader #(
  parameter int DPW   = 32,
  parameter int Depth = 120,
  parameter int CntW  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [DPW-1:0]  base_addr,
  input  logic [CntW-1:0] word_cnt,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [DPW-1:0]  s_data,
  output logic            data_en,
  output logic [DPW-1:0]  input_data,
  output logic [DPW-1:0]  input_addr,
  input  logic [DPW-1:0]  output_check,
  output logic            busy,
  output logic            done,
  output logic [2:0]      err,
  output logic [CntW-1:0] words_loaded
);

  // Wide enough that base + 4*count can never wrap.
  localparam int SumW = DPW + CntW + 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
`ifdef DCACHE_LOADER_READBACK_EN
    VERIFY = 2'd2,
`endif
    DONE   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [DPW-1:0]  addr_q, addr_d;          // address of the next word to accept
  logic [CntW-1:0] rem_q, rem_d;            // words still to accept
  logic [CntW-1:0] words_loaded_q, words_loaded_d;
  logic [DPW-1:0]  input_data_q, input_data_d;
  logic [DPW-1:0]  input_addr_q, input_addr_d;
  logic            data_en_q, data_en_d;
  logic [2:0]      err_q, err_d;

`ifdef DCACHE_LOADER_READBACK_EN
  // VERIFY spans two cycles: the write cycle (phase 0) and the compare cycle (phase 1).
  logic            vphase_q, vphase_d;
`else
  logic            unused_check;
  assign unused_check = ^output_check;
`endif

  logic [SumW-1:0] end_byte;
  assign end_byte = SumW'(base_addr) + (SumW'(word_cnt) << 2);

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    rem_d          = rem_q;
    words_loaded_d = words_loaded_q;
    input_data_d   = input_data_q;
    input_addr_d   = input_addr_q;
    data_en_d      = 1'b0;
    err_d          = err_q;
    s_ready        = 1'b0;
`ifdef DCACHE_LOADER_READBACK_EN
    vphase_d       = vphase_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          err_d          = 3'b000;
          words_loaded_d = '0;
          addr_d         = base_addr;
          rem_d          = word_cnt;
          if (base_addr[1:0] != 2'b00) begin
            err_d[1] = 1'b1;
            state_d  = DONE;
          end else if (end_byte > SumW'(Depth)) begin
            err_d[0] = 1'b1;
            state_d  = DONE;
          end else if (word_cnt == '0) begin
            state_d  = DONE;
          end else begin
            state_d  = LOAD;
          end
        end
      end

      LOAD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          input_data_d   = s_data;
          input_addr_d   = addr_q;
          data_en_d      = 1'b1;
          addr_d         = addr_q + DPW'(4);
          words_loaded_d = words_loaded_q + CntW'(1);
          rem_d          = rem_q - CntW'(1);
`ifdef DCACHE_LOADER_READBACK_EN
          state_d        = VERIFY;
          vphase_d       = 1'b0;
`else
          if (rem_q == CntW'(1)) state_d = DONE;
`endif
        end
      end

`ifdef DCACHE_LOADER_READBACK_EN
      VERIFY: begin
        if (!vphase_q) begin
          vphase_d = 1'b1;
        end else begin
          // The cache wrote at the end of the previous cycle, so its readback is current now.
          if (output_check != input_data_q) err_d[2] = 1'b1;
          state_d = (rem_q == '0) ? DONE : LOAD;
        end
      end
`endif

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      rem_q          <= '0;
      words_loaded_q <= '0;
      input_data_q   <= '0;
      input_addr_q   <= '0;
      data_en_q      <= 1'b0;
      err_q          <= 3'b000;
`ifdef DCACHE_LOADER_READBACK_EN
      vphase_q       <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      rem_q          <= rem_d;
      words_loaded_q <= words_loaded_d;
      input_data_q   <= input_data_d;
      input_addr_q   <= input_addr_d;
      data_en_q      <= data_en_d;
      err_q          <= err_d;
`ifdef DCACHE_LOADER_READBACK_EN
      vphase_q       <= vphase_d;
`endif
    end
  end

  assign data_en      = data_en_q;
  assign input_data   = input_data_q;
  assign input_addr   = input_addr_q;
  assign err          = err_q;
  assign words_loaded = words_loaded_q;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);

endmodule
